dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
- Sequences data-memory accesses for the MEM stage.
- Takes the memory control fields carried out of the EX/MEM pipeline register: Enable, rw, Size, plus the address and store data.
- Drives a req/ack memory port with byte enables and lane alignment.
- Stalls the pipeline until each access completes, faults, or times out.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, memory data width (fixed four byte lanes)
TIMEOUT, 15, maximum BUSY cycles without mem_ack before a fault

Ports:
CLK  in  1  clock, rising edge
CLR  in  1  reset, asynchronous, active-low
Enable_In  in  1  memory access requested by the instruction in MEM
rw_In  in  1  0 = read, 1 = write
Size_In  in  2  00 byte, 01 halfword, 10 word, 11 reserved
Addr_In  in  ADDR_W  byte address
WData_In  in  DATA_W  store data, right-justified
mem_req  out  1  memory request, held until ack
mem_we  out  1  write strobe qualifier
mem_addr  out  ADDR_W  word-aligned address {Addr[ADDR_W-1:2],2'b00}
mem_be  out  4  byte-lane enables
mem_wdata  out  DATA_W  store data replicated across lanes
mem_rdata  in  DATA_W  read data, valid with mem_ack
mem_ack  in  1  memory completes the request this cycle
Stall_Out  out  1  hold pipeline (combinational)
Done_Out  out  1  one-cycle pulse, access complete
RData_Out  out  DATA_W  aligned, zero-extended load data, held until next load completes
Fault_Out  out  1  one-cycle pulse, misaligned, reserved size, or timeout

Behaviour:
- Reset (CLR=0, asynchronous): state IDLE, all outputs 0, timeout counter 0. mem_req drops immediately, including mid-access. The in-flight access is abandoned; no Done or Fault is issued.
- States: IDLE, BUSY, DONE, FAULT.
- Legal access:
  - Size != 11.
  - Halfword requires Addr[0] = 0.
  - Word requires Addr[1:0] = 00.
- IDLE:
  - Enable_In=0: remain IDLE. mem_ack is ignored.
  - Enable_In=1 and legal: register addr, size, rw, lane data and be; go to BUSY. Stall_Out=1 in this same cycle.
  - Enable_In=1 and illegal: go to FAULT with no memory request. Stall_Out=1 in this cycle.
- BUSY:
  - mem_req=1; mem_we, mem_addr, mem_be and mem_wdata stay stable from registers.
  - Stall_Out=1. The counter increments each BUSY cycle.
  - mem_ack=1: on a read, register RData_Out from mem_rdata, then go to DONE. The counter clears.
  - mem_ack=0 with counter = TIMEOUT-1: go to FAULT. mem_req drops on entry.
  - Minimum latency: request accepted at cycle 0, BUSY at cycle 1, ack at cycle 1, Done at cycle 2.
- DONE: Done_Out=1, Stall_Out=0, mem_req=0. The pipeline advances on this edge. Next state IDLE unconditionally; the held instruction is never re-issued.
- FAULT: Fault_Out=1, Stall_Out=0, mem_req=0. RData_Out is unchanged. Next state IDLE.
- Byte enables:
  - byte = 4'b0001 << Addr[1:0]
  - halfword = 4'b0011 << {Addr[1],1'b0}
  - word = 4'b1111
- Write data lanes:
  - byte: {4{WData[7:0]}}
  - halfword: {2{WData[15:0]}}
  - word: as is
- Read extract: the selected lane is shifted to bit 0 and the upper bits are zero-filled.
- mem_we = registered rw. It is 0 whenever mem_req = 0.
- mem_ack while not BUSY: ignored, no state change.
- Enable_In changing while BUSY: ignored (inputs captured at accept).

Decomposition:
- dmem_ctrl_pkg:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD
  - state enum
  - TIMEOUT default
- Sub-module dmem_lane_align (combinational). Inputs: size, addr[1:0], wdata, rdata. Outputs: be, lane wdata, extracted rdata, legal flag.
- The FSM and counter live in dmem_access_ctrl.

Test Plan:
- Word read at 0x100, ack one cycle after req, rdata=0xDEADBEEF:
  - mem_be=1111, mem_addr=0x100.
  - Stall high for 2 cycles.
  - Done pulse, RData_Out=0xDEADBEEF.
- Byte write at 0x203, WData=0x000000A5, ack after 3 cycles:
  - mem_be=1000, mem_wdata=0xA5A5A5A5, mem_we=1.
  - mem_req held all 3 cycles, then Done.
- Halfword read at 0x102, rdata=0x12345678: mem_be=1100, RData_Out=0x00001234.
- Halfword at 0x101, or Size=11: no mem_req, Fault pulse next cycle, Stall released, RData_Out unchanged.
- Word read with ack never asserted: mem_req high for 15 cycles, then Fault pulse and mem_req=0.
- CLR low during BUSY:
  - mem_req, Stall_Out and Done_Out go to 0 immediately (before next edge).
  - After release, a new read completes normally.
  - A stray mem_ack in IDLE has no effect.

Source files
------------

// File: rtl/dmem_ctrl_pkg.sv
// Shared encodings for the MEM-stage data-memory access controller.
// Contents: access size codes, FSM state codes, default timeout.
// No logic; imported by dmem_lane_align and dmem_access_ctrl.
package dmem_ctrl_pkg;

  // Access size field as carried in the EX/MEM register
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // Controller state encodings
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_BUSY  = 2'd1;
  localparam state_t ST_DONE  = 2'd2;
  localparam state_t ST_FAULT = 2'd3;

  // Maximum BUSY cycles without an ack before the access faults
  localparam int TIMEOUT_DEF = 15;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane alignment for a 4-lane data memory: legality, byte enables, store replication, load extract.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the outputs are used.
// Ports: size/addr_lo select the access; wdata/rdata are the raw store/load words;
//        be, lane_wdata, rdata_ext and legal are the derived lane-level views.
module dmem_lane_align
  import dmem_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        size,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [3:0]        be,
  output logic [DATA_W-1:0] lane_wdata,
  output logic [DATA_W-1:0] rdata_ext,
  output logic              legal
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  // Pick the addressed lane(s) out of the full word
  assign rd_byte = rdata[{addr_lo, 3'b000} +: 8];
  assign rd_half = rdata[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    be         = 4'b0000;
    lane_wdata = wdata;
    rdata_ext  = '0;
    legal      = 1'b0;
    case (size)
      SZ_BYTE: begin
        legal      = 1'b1;
        be         = 4'b0001 << addr_lo;
        lane_wdata = {4{wdata[7:0]}};
        rdata_ext  = {{(DATA_W-8){1'b0}}, rd_byte};
      end
      SZ_HALF: begin
        legal      = ~addr_lo[0];
        be         = 4'b0011 << {addr_lo[1], 1'b0};
        lane_wdata = {2{wdata[15:0]}};
        rdata_ext  = {{(DATA_W-16){1'b0}}, rd_half};
      end
      SZ_WORD: begin
        legal      = (addr_lo == 2'b00);
        be         = 4'b1111;
        lane_wdata = wdata;
        rdata_ext  = rdata;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access sequencer driving a req/ack port with lane alignment.
// Latency: accept at cycle 0, request from cycle 1, Done the cycle after ack (min 2 cycles).
// Backpressure: Stall_Out holds the pipeline until Done, Fault or timeout; mem_req held until ack.
// Ports: CLK/CLR clock and async active-low reset; *_In access fields from EX/MEM;
//        mem_* memory port; Stall_Out/Done_Out/Fault_Out/RData_Out back to the pipeline.
module dmem_access_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              Enable_In,
  input  logic              rw_In,
  input  logic [1:0]        Size_In,
  input  logic [ADDR_W-1:0] Addr_In,
  input  logic [DATA_W-1:0] WData_In,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              Stall_Out,
  output logic              Done_Out,
  output logic [DATA_W-1:0] RData_Out,
  output logic              Fault_Out
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                we_q;
  logic [1:0]          size_q;
  logic [1:0]          lo_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [3:0]          be_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;

  logic                busy;
  logic [1:0]          al_size;
  logic [1:0]          al_lo;
  logic [3:0]          al_be;
  logic [DATA_W-1:0]   al_wdata;
  logic [DATA_W-1:0]   al_rdata;
  logic                al_legal;

  assign busy = (state == ST_BUSY);

  // One aligner serves both ends of the access: while IDLE it decodes the
  // incoming request, while BUSY it extracts load data using the captured
  // size/offset, so the extract never sees a changed Size_In/Addr_In.
  assign al_size = busy ? size_q : Size_In;
  assign al_lo   = busy ? lo_q   : Addr_In[1:0];

  dmem_lane_align #(
    .DATA_W (DATA_W)
  ) u_lane_align (
    .size       (al_size),
    .addr_lo    (al_lo),
    .wdata      (WData_In),
    .rdata      (mem_rdata),
    .be         (al_be),
    .lane_wdata (al_wdata),
    .rdata_ext  (al_rdata),
    .legal      (al_legal)
  );

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      lo_q    <= 2'b00;
      addr_q  <= '0;
      be_q    <= 4'b0000;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (Enable_In) begin
            if (al_legal) begin
              we_q    <= rw_In;
              size_q  <= Size_In;
              lo_q    <= Addr_In[1:0];
              addr_q  <= {Addr_In[ADDR_W-1:2], 2'b00};
              be_q    <= al_be;
              wdata_q <= al_wdata;
              state   <= ST_BUSY;
            end else begin
              state <= ST_FAULT;
            end
          end
        end
        ST_BUSY: begin
          if (mem_ack) begin
            if (!we_q) begin
              rdata_q <= al_rdata;
            end
            cnt   <= '0;
            state <= ST_DONE;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            cnt   <= '0;
            state <= ST_FAULT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_req   = busy;
  assign mem_we    = busy & we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign RData_Out = rdata_q;
  assign Done_Out  = (state == ST_DONE);
  assign Fault_Out = (state == ST_FAULT);

  // Stall covers the accept cycle too; CLR gates it so the pipeline is
  // released the moment reset asserts even if Enable_In is still high.
  assign Stall_Out = CLR & (busy | ((state == ST_IDLE) & Enable_In));

endmodule

// File: tb/tb_dmem_access_ctrl.sv
module tb_dmem_access_ctrl;

  logic        CLK = 1'b0;
  logic        CLR;
  logic        Enable_In;
  logic        rw_In;
  logic [1:0]  Size_In;
  logic [31:0] Addr_In;
  logic [31:0] WData_In;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        Stall_Out;
  logic        Done_Out;
  logic [31:0] RData_Out;
  logic        Fault_Out;

  int total = 0;
  int bad   = 0;
  int nreq;

  always #5 CLK = ~CLK;

  dmem_access_ctrl #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (15)
  ) dut (
    .CLK       (CLK),
    .CLR       (CLR),
    .Enable_In (Enable_In),
    .rw_In     (rw_In),
    .Size_In   (Size_In),
    .Addr_In   (Addr_In),
    .WData_In  (WData_In),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .Stall_Out (Stall_Out),
    .Done_Out  (Done_Out),
    .RData_Out (RData_Out),
    .Fault_Out (Fault_Out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
  task automatic next();
    @(posedge CLK);
    #1;
  endtask

  task automatic mid();
    @(negedge CLK);
  endtask

  initial begin
    CLR = 1'b1; Enable_In = 1'b0; rw_In = 1'b0; Size_In = 2'b00;
    Addr_In = 32'h0; WData_In = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
    #2 CLR = 1'b0;

    // Reset state
    mid();
    chk("rst_req",   32'(mem_req),   32'h0);
    chk("rst_stall", 32'(Stall_Out), 32'h0);
    chk("rst_done",  32'(Done_Out),  32'h0);
    chk("rst_fault", 32'(Fault_Out), 32'h0);
    chk("rst_rdata", RData_Out,      32'h0);
    chk("rst_be",    32'(mem_be),    32'h0);
    next();
    CLR = 1'b1;

    // Word read at 0x100, ack in first BUSY cycle
    next();
    Enable_In = 1'b1; rw_In = 1'b0; Size_In = 2'b10; Addr_In = 32'h100;
    mid();
    chk("wr0_stall", 32'(Stall_Out), 32'h1);
    chk("wr0_req",   32'(mem_req),   32'h0);
    next();
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    mid();
    chk("wr1_req",   32'(mem_req),   32'h1);
    chk("wr1_be",    32'(mem_be),    32'hF);
    chk("wr1_addr",  mem_addr,       32'h100);
    chk("wr1_we",    32'(mem_we),    32'h0);
    chk("wr1_stall", 32'(Stall_Out), 32'h1);
    next();
    mem_ack = 1'b0; Enable_In = 1'b0;
    mid();
    chk("wr2_done",  32'(Done_Out),  32'h1);
    chk("wr2_stall", 32'(Stall_Out), 32'h0);
    chk("wr2_req",   32'(mem_req),   32'h0);
    chk("wr2_rdata", RData_Out,      32'hDEADBEEF);
    next();
    mid();
    chk("wr3_done",  32'(Done_Out),  32'h0);

    // Byte write at 0x203, ack after 3 BUSY cycles
    next();
    Enable_In = 1'b1; rw_In = 1'b1; Size_In = 2'b00; Addr_In = 32'h203; WData_In = 32'h000000A5;
    mid();
    chk("bw0_stall", 32'(Stall_Out), 32'h1);
    for (int i = 1; i <= 3; i++) begin
      next();
      if (i == 3) mem_ack = 1'b1;
      mid();
      chk("bw_req",   32'(mem_req),   32'h1);
      chk("bw_we",    32'(mem_we),    32'h1);
      chk("bw_be",    32'(mem_be),    32'h8);
      chk("bw_wdata", mem_wdata,      32'hA5A5A5A5);
      chk("bw_addr",  mem_addr,       32'h200);
      chk("bw_stall", 32'(Stall_Out), 32'h1);
    end
    next();
    mem_ack = 1'b0; Enable_In = 1'b0;
    mid();
    chk("bw_done",  32'(Done_Out), 32'h1);
    chk("bw_we_lo", 32'(mem_we),   32'h0);
    chk("bw_rdata", RData_Out,     32'hDEADBEEF);

    // Halfword read at 0x102
    next();
    Enable_In = 1'b1; rw_In = 1'b0; Size_In = 2'b01; Addr_In = 32'h102;
    mid();
    next();
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    mid();
    chk("hr_be",   32'(mem_be), 32'hC);
    chk("hr_addr", mem_addr,    32'h100);
    chk("hr_req",  32'(mem_req), 32'h1);
    next();
    mem_ack = 1'b0; Enable_In = 1'b0;
    mid();
    chk("hr_done",  32'(Done_Out), 32'h1);
    chk("hr_rdata", RData_Out,     32'h00001234);

    // Misaligned halfword at 0x101
    next();
    Enable_In = 1'b1; Size_In = 2'b01; Addr_In = 32'h101;
    mid();
    chk("mis0_stall", 32'(Stall_Out), 32'h1);
    chk("mis0_req",   32'(mem_req),   32'h0);
    next();
    Enable_In = 1'b0;
    mid();
    chk("mis1_fault", 32'(Fault_Out), 32'h1);
    chk("mis1_req",   32'(mem_req),   32'h0);
    chk("mis1_stall", 32'(Stall_Out), 32'h0);
    chk("mis1_done",  32'(Done_Out),  32'h0);
    chk("mis1_rdata", RData_Out,      32'h00001234);

    // Reserved size
    next();
    Enable_In = 1'b1; Size_In = 2'b11; Addr_In = 32'h100;
    mid();
    chk("rsv0_req", 32'(mem_req), 32'h0);
    next();
    Enable_In = 1'b0;
    mid();
    chk("rsv1_fault", 32'(Fault_Out), 32'h1);
    chk("rsv1_rdata", RData_Out,      32'h00001234);
    next();
    mid();
    chk("rsv2_fault", 32'(Fault_Out), 32'h0);

    // Word read that is never acked: timeout after 15 request cycles
    next();
    Enable_In = 1'b1; rw_In = 1'b0; Size_In = 2'b10; Addr_In = 32'h300;
    mid();
    next();
    nreq = 0;
    for (int i = 0; i < 40; i++) begin
      mid();
      if (!mem_req) break;
      nreq++;
      next();
    end
    Enable_In = 1'b0;
    chk("to_reqcnt", 32'(nreq),      32'd15);
    chk("to_fault",  32'(Fault_Out), 32'h1);
    chk("to_req",    32'(mem_req),   32'h0);
    chk("to_rdata",  RData_Out,      32'h00001234);

    // Reset asserted mid-access
    next();
    Enable_In = 1'b1; rw_In = 1'b0; Size_In = 2'b10; Addr_In = 32'h400;
    mid();
    next();
    mid();
    chk("cl_req_busy", 32'(mem_req), 32'h1);
    #2 CLR = 1'b0;
    #1;
    chk("cl_req",   32'(mem_req),   32'h0);
    chk("cl_stall", 32'(Stall_Out), 32'h0);
    chk("cl_done",  32'(Done_Out),  32'h0);
    chk("cl_rdata", RData_Out,      32'h0);
    next();
    CLR = 1'b1; Enable_In = 1'b0;

    // Stray ack while idle
    next();
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    mid();
    chk("st_req",   32'(mem_req),   32'h0);
    chk("st_stall", 32'(Stall_Out), 32'h0);
    next();
    mid();
    chk("st_done",  32'(Done_Out),  32'h0);
    chk("st_fault", 32'(Fault_Out), 32'h0);
    chk("st_rdata", RData_Out,      32'h0);

    // Byte read at 0x401 after reset
    next();
    mem_ack = 1'b0; Enable_In = 1'b1; rw_In = 1'b0; Size_In = 2'b00; Addr_In = 32'h401;
    mid();
    chk("br0_stall", 32'(Stall_Out), 32'h1);
    next();
    mem_ack = 1'b1; mem_rdata = 32'hAABBCCDD;
    mid();
    chk("br1_be",  32'(mem_be),  32'h2);
    chk("br1_req", 32'(mem_req), 32'h1);
    next();
    mem_ack = 1'b0; Enable_In = 1'b0;
    mid();
    chk("br2_done",  32'(Done_Out), 32'h1);
    chk("br2_rdata", RData_Out,     32'h000000CC);
    next();
    mid();
    chk("br3_done",  32'(Done_Out),  32'h0);
    chk("br3_stall", 32'(Stall_Out), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
